mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mul_div_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / divide unit with HI/LO result
// registers and MTHI/MTLO write ports.
// Sequence: IDLE -> PREP (operand magnitudes, result signs) -> RUN (one
// shift-add or restoring shift-subtract step per cycle) -> FIX (sign
// correction, HI/LO write, done pulse).
// Build option: define MUL_DIV_UNIT_DIV_EN to include the divider datapath.
// Without it, DIV/DIVU go PREP -> FIX, leave HI/LO untouched and still
// pulse done.
module mul_div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt;

    // Operands captured at the accepting edge (op[0]=1 means unsigned)
    logic [1:0]               op_p0;
    logic signed [DATA_W-1:0] a_p0;
    logic signed [DATA_W-1:0] b_p0;

    // PREP results: the non-accumulator operand magnitude and result signs
    logic [DATA_W-1:0] mag_p1;
    logic              neg_res_p1;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic              neg_rem_p1;
`endif

    // Iteration accumulator: {hi-part, lo-part}; for multiply this is
    // {partial sum, remaining multiplier bits}, for divide {remainder, quotient}
    logic [2*DATA_W-1:0] acc_p2;
    logic [2*DATA_W-1:0] acc_step;
    logic [DATA_W:0]     mul_sum;
`ifdef MUL_DIV_UNIT_DIV_EN
    logic [DATA_W:0]     div_trial;
`endif

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;
    logic                res_wr;

    logic accept;
    logic sgn;

    function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] x,
                                                   input logic neg);
        cond_neg = neg ? -x : x;
    endfunction

    function automatic logic [2*DATA_W-1:0] cond_neg_wide(input logic [2*DATA_W-1:0] x,
                                                          input logic neg);
        cond_neg_wide = neg ? -x : x;
    endfunction

    function automatic logic [DATA_W-1:0] mag_of(input logic signed [DATA_W-1:0] x,
                                                 input logic is_signed);
        mag_of = cond_neg(x, is_signed & x[DATA_W-1]);
    endfunction

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start;
    assign sgn    = ~op_p0[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = PREP;
`ifdef MUL_DIV_UNIT_DIV_EN
            PREP: state_nxt = RUN;
`else
            PREP: state_nxt = op_p0[1] ? FIX : RUN;
`endif
            RUN:  if (cnt == CNT_W'(DATA_W - 1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration counter, restarted on entry to RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == PREP) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
        end
    end

    // One multiply (shift-add) or divide (restoring) step
    always_comb begin
        mul_sum  = {1'b0, acc_p2[2*DATA_W-1:DATA_W]} + (acc_p2[0] ? {1'b0, mag_p1} : '0);
        acc_step = {mul_sum, acc_p2[DATA_W-1:1]};
`ifdef MUL_DIV_UNIT_DIV_EN
        div_trial = {acc_p2[2*DATA_W-1:DATA_W], acc_p2[DATA_W-1]} - {1'b0, mag_p1};
        if (op_p0[1]) begin
            if (!div_trial[DATA_W]) begin
                acc_step = {div_trial[DATA_W-1:0], acc_p2[DATA_W-2:0], 1'b1};
            end else begin
                acc_step = {acc_p2[2*DATA_W-2:0], 1'b0};
            end
        end
`endif
    end

    // Datapath: operand capture, PREP setup, RUN iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0 <= op;
            a_p0  <= a;
            b_p0  <= b;
        end
        if (state == PREP) begin
            mag_p1     <= op_p0[1] ? mag_of(b_p0, sgn) : mag_of(a_p0, sgn);
            neg_res_p1 <= sgn & (a_p0[DATA_W-1] ^ b_p0[DATA_W-1]);
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_rem_p1 <= sgn & a_p0[DATA_W-1];
`endif
            acc_p2     <= {{DATA_W{1'b0}},
                           op_p0[1] ? mag_of(a_p0, sgn) : mag_of(b_p0, sgn)};
        end else if (state == RUN) begin
            acc_p2 <= acc_step;
        end
    end

    // Final sign correction and special divide cases
    always_comb begin
        prod   = cond_neg_wide(acc_p2, neg_res_p1);
        res_wr = 1'b1;
        res_hi = prod[2*DATA_W-1:DATA_W];
        res_lo = prod[DATA_W-1:0];
        if (op_p0[1]) begin
`ifdef MUL_DIV_UNIT_DIV_EN
            if (b_p0 == '0) begin
                res_lo = '1;
                res_hi = a_p0;
            end else begin
                res_lo = cond_neg(acc_p2[DATA_W-1:0], neg_res_p1);
                res_hi = cond_neg(acc_p2[2*DATA_W-1:DATA_W], neg_rem_p1);
            end
`else
            res_wr = 1'b0;
`endif
        end
    end

    // HI/LO registers: result write in FIX, MTHI/MTLO only when idle without start
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            if (res_wr) begin
                hi <= res_hi;
                lo <= res_lo;
            end
        end else if ((state == IDLE) && !start) begin
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
        end
    end

    // Done pulse, one cycle after FIX
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= (state == FIX);
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed testbench for mul_div_unit. Divide checks follow the build option
// MUL_DIV_UNIT_DIV_EN.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (wr_hi),
        .wr_lo (wr_lo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Called at a negedge; returns just after the accepting edge with
    // operands scrambled so late changes cannot leak into the result.
    task automatic do_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h13579BDF;
        op    = ~o;
    endtask

    // Counts negedges until done is seen, bounded at 100.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd5;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hFFFF0000;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        @(negedge clk);
        total++;
        if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
        total++;
        if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    endtask

    task automatic test_mt();
        int n;
        wr_hi = 1'b1;
        wr_lo = 1'b1;
        wdata = 32'hA5A50F0F;
        @(negedge clk);
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        total++;
        if (hi !== 32'hA5A50F0F) begin bad++; $display("FAIL mt_both_hi got=%h exp=%h", hi, 32'hA5A50F0F); end
        total++;
        if (lo !== 32'hA5A50F0F) begin bad++; $display("FAIL mt_both_lo got=%h exp=%h", lo, 32'hA5A50F0F); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL mt_done got=%b exp=0", done); end
        wr_lo = 1'b1;
        wdata = 32'h00000011;
        @(negedge clk);
        wr_lo = 1'b0;
        total++;
        if (lo !== 32'h00000011) begin bad++; $display("FAIL mtlo_lo got=%h exp=%h", lo, 32'h11); end
        total++;
        if (hi !== 32'hA5A50F0F) begin bad++; $display("FAIL mtlo_hi got=%h exp=%h", hi, 32'hA5A50F0F); end
        // write in the same cycle as an accepted start is dropped
        wr_hi = 1'b1;
        wdata = 32'h00000099;
        do_start(OP_MULTU, 32'd2, 32'd3);
        wr_hi = 1'b0;
        total++;
        if (hi !== 32'hA5A50F0F) begin bad++; $display("FAIL mt_with_start_hi got=%h exp=%h", hi, 32'hA5A50F0F); end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mt_start_busy got=%b exp=1", busy); end
        // write while busy is dropped
        wr_lo = 1'b1;
        wdata = 32'h00000077;
        @(negedge clk);
        wr_lo = 1'b0;
        total++;
        if (lo !== 32'h00000011) begin bad++; $display("FAIL mt_busy_lo got=%h exp=%h", lo, 32'h11); end
        wait_done(n);
        total++;
        if (n != 33) begin bad++; $display("FAIL mt_op_latency got=%0d exp=33", n); end
        total++;
        if (hi !== 32'h0) begin bad++; $display("FAIL mt_op_hi got=%h exp=%h", hi, 32'h0); end
        total++;
        if (lo !== 32'd6) begin bad++; $display("FAIL mt_op_lo got=%h exp=%h", lo, 32'd6); end
        @(negedge clk);
    endtask

    task automatic test_mult();
        int n;
        do_start(OP_MULT, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL mult_latency got=%0d exp=34", n); end
        total++;
        if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
        total++;
        if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL mult_lo got=%h exp=%h", lo, 32'hFFFFFFFA); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse got=%b exp=0", done); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mult_busy_after got=%b exp=0", busy); end

        do_start(OP_MULTU, 32'hFFFFFFFE, 32'd3);
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL multu_latency got=%0d exp=34", n); end
        total++;
        if (hi !== 32'h00000002) begin bad++; $display("FAIL multu_hi got=%h exp=%h", hi, 32'h2); end
        total++;
        if (lo !== 32'hFFFFFFFA) begin bad++; $display("FAIL multu_lo got=%h exp=%h", lo, 32'hFFFFFFFA); end

        do_start(OP_MULT, 32'h80000000, 32'h80000000);
        wait_done(n);
        total++;
        if (hi !== 32'h40000000) begin bad++; $display("FAIL mult_minmin_hi got=%h exp=%h", hi, 32'h40000000); end
        total++;
        if (lo !== 32'h00000000) begin bad++; $display("FAIL mult_minmin_lo got=%h exp=%h", lo, 32'h0); end

        do_start(OP_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(n);
        total++;
        if (hi !== 32'h00000000) begin bad++; $display("FAIL mult_m1m1_hi got=%h exp=%h", hi, 32'h0); end
        total++;
        if (lo !== 32'h00000001) begin bad++; $display("FAIL mult_m1m1_lo got=%h exp=%h", lo, 32'h1); end
        @(negedge clk);
    endtask

`ifdef MUL_DIV_UNIT_DIV_EN
    task automatic test_div();
        int n;
        do_start(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL div_latency got=%0d exp=34", n); end
        total++;
        if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
        total++;
        if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end

        do_start(OP_DIVU, 32'd100, 32'd0);
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL divu0_latency got=%0d exp=34", n); end
        total++;
        if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu0_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
        total++;
        if (hi !== 32'd100) begin bad++; $display("FAIL divu0_hi got=%h exp=%h", hi, 32'd100); end

        do_start(OP_DIV, 32'hFFFFFFFB, 32'd0);
        wait_done(n);
        total++;
        if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_lo got=%h exp=%h", lo, 32'hFFFFFFFF); end
        total++;
        if (hi !== 32'hFFFFFFFB) begin bad++; $display("FAIL div0_hi got=%h exp=%h", hi, 32'hFFFFFFFB); end

        do_start(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(n);
        total++;
        if (lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h exp=%h", lo, 32'h80000000); end
        total++;
        if (hi !== 32'h00000000) begin bad++; $display("FAIL div_ovf_hi got=%h exp=%h", hi, 32'h0); end

        do_start(OP_DIV, 32'd7, 32'hFFFFFFFE);
        wait_done(n);
        total++;
        if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_posneg_lo got=%h exp=%h", lo, 32'hFFFFFFFD); end
        total++;
        if (hi !== 32'h00000001) begin bad++; $display("FAIL div_posneg_hi got=%h exp=%h", hi, 32'h1); end

        do_start(OP_DIVU, 32'hFFFFFFFF, 32'h10);
        wait_done(n);
        total++;
        if (lo !== 32'h0FFFFFFF) begin bad++; $display("FAIL divu_big_lo got=%h exp=%h", lo, 32'h0FFFFFFF); end
        total++;
        if (hi !== 32'h0000000F) begin bad++; $display("FAIL divu_big_hi got=%h exp=%h", hi, 32'hF); end
        @(negedge clk);
    endtask
`else
    task automatic test_div();
        int n;
        wr_lo = 1'b1;
        wdata = 32'd5;
        @(negedge clk);
        wr_lo = 1'b0;
        wr_hi = 1'b1;
        wdata = 32'h00000ABC;
        @(negedge clk);
        wr_hi = 1'b0;
        total++;
        if (lo !== 32'd5) begin bad++; $display("FAIL nodiv_mtlo got=%h exp=%h", lo, 32'd5); end
        do_start(OP_DIVU, 32'd9, 32'd3);
        wait_done(n);
        total++;
        if (n != 2) begin bad++; $display("FAIL nodiv_divu_latency got=%0d exp=2", n); end
        total++;
        if (lo !== 32'd5) begin bad++; $display("FAIL nodiv_divu_lo got=%h exp=%h", lo, 32'd5); end
        total++;
        if (hi !== 32'h00000ABC) begin bad++; $display("FAIL nodiv_divu_hi got=%h exp=%h", hi, 32'hABC); end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL nodiv_done_pulse got=%b exp=0", done); end
        do_start(OP_DIV, 32'hFFFFFFF8, 32'd2);
        wait_done(n);
        total++;
        if (n != 2) begin bad++; $display("FAIL nodiv_div_latency got=%0d exp=2", n); end
        total++;
        if (lo !== 32'd5) begin bad++; $display("FAIL nodiv_div_lo got=%h exp=%h", lo, 32'd5); end
        @(negedge clk);
    endtask
`endif

    task automatic test_busy_ignore();
        int n;
        do_start(OP_MULTU, 32'h00010000, 32'h00010000);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd1;
        b     = 32'd1;
        wr_lo = 1'b1;
        wr_hi = 1'b1;
        wdata = 32'hFFFFFFFF;
        @(negedge clk);
        start = 1'b0;
        wr_lo = 1'b0;
        wr_hi = 1'b0;
        wait_done(n);
        total++;
        if (n != 29) begin bad++; $display("FAIL ignore_latency got=%0d exp=29", n); end
        total++;
        if (hi !== 32'h00000001) begin bad++; $display("FAIL ignore_hi got=%h exp=%h", hi, 32'h1); end
        total++;
        if (lo !== 32'h00000000) begin bad++; $display("FAIL ignore_lo got=%h exp=%h", lo, 32'h0); end
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL ignore_no_second_op got=%b exp=0", busy); end
    endtask

    task automatic test_rst_mid();
        int seen;
        do_start(OP_MULT, 32'd7, 32'd9);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (hi !== 32'h0) begin bad++; $display("FAIL rstmid_hi got=%h exp=%h", hi, 32'h0); end
        total++;
        if (lo !== 32'h0) begin bad++; $display("FAIL rstmid_lo got=%h exp=%h", lo, 32'h0); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", seen); end
        wr_hi = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        wr_hi = 1'b0;
        total++;
        if (hi !== 32'h12345678) begin bad++; $display("FAIL rstmid_mthi got=%h exp=%h", hi, 32'h12345678); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_start(OP_MULTU, 32'd5, 32'd7);
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=34", n); end
        total++;
        if (lo !== 32'd35) begin bad++; $display("FAIL b2b_first_lo got=%h exp=%h", lo, 32'd35); end
        do_start(OP_MULT, 32'd6, 32'hFFFFFFF9);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_second_busy got=%b exp=1", busy); end
        wait_done(n);
        total++;
        if (n != 34) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=34", n); end
        total++;
        if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL b2b_second_hi got=%h exp=%h", hi, 32'hFFFFFFFF); end
        total++;
        if (lo !== 32'hFFFFFFD6) begin bad++; $display("FAIL b2b_second_lo got=%h exp=%h", lo, 32'hFFFFFFD6); end
        @(negedge clk);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        wr_hi = 1'b0;
        wr_lo = 1'b0;
        wdata = '0;
        test_reset();
        test_mt();
        test_mult();
        test_div();
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
